// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO family.
package fifo_pkg;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } fifo_rd_mode_e;

    // Occupancy counter must be able to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: DATA_W x DEPTH, synchronous write, asynchronous read.
// Latency: write visible one cycle after the write edge; read is combinational.
// Backpressure: none, the controller owns all flow control.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO of arbitrary depth with level flags, flush and sticky errors.
// Latency: registered read returns data one cycle after pop; FWFT shows head word one cycle after push.
// Backpressure: push refused when full unless a pop is accepted in the same cycle.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter bit FWFT      = 1'b0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         pop_data_o,
    output logic                      pop_valid_o,
    output logic                      fifo_full_o,
    output logic                      fifo_empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      overflow_o,
    output logic                      underflow_o,
    input  logic                      err_clr_i
);

    localparam int            CNT_W   = cnt_w(DEPTH);
    localparam int            PTR_W   = $clog2(DEPTH);
    localparam fifo_rd_mode_e RD_MODE = FWFT ? RD_FWFT : RD_REG;

    if (DEPTH < 2) begin : g_chk_depth
        $fatal(1, "sync_fifo_ctrl: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $fatal(1, "sync_fifo_ctrl: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
        $fatal(1, "sync_fifo_ctrl: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] rd_data;
    logic              pop_acc;
    logic              push_acc;
    logic              ovf_set;
    logic              udf_set;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_acc  = pop_i && !fifo_empty_o;
        push_acc = push_i && (!fifo_full_o || pop_acc);
        ovf_set  = push_i && !push_acc && !flush_i;
        udf_set  = pop_i && fifo_empty_o && !flush_i;
        cnt_nxt  = count_o;
        if (flush_i) begin
            cnt_nxt = '0;
        end else if (push_acc && !pop_acc) begin
            cnt_nxt = count_o + 1'b1;
        end else if (pop_acc && !push_acc) begin
            cnt_nxt = count_o - 1'b1;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc && !flush_i),
        .waddr (wr_ptr),
        .wdata (push_data_i),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Flags come from the next count so they always agree with count_o.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            fifo_full_o    <= 1'b0;
            fifo_empty_o   <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            count_o        <= cnt_nxt;
            fifo_full_o    <= (int'(cnt_nxt) == DEPTH);
            fifo_empty_o   <= (cnt_nxt == '0);
            almost_full_o  <= (int'(cnt_nxt) >= AF_THRESH);
            almost_empty_o <= (int'(cnt_nxt) <= AE_THRESH);
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop_acc) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_set || (overflow_o && !err_clr_i);
            underflow_o <= udf_set || (underflow_o && !err_clr_i);
        end
    end

    if (RD_MODE == RD_REG) begin : g_rd_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pop_data_o  <= '0;
                pop_valid_o <= 1'b0;
            end else begin
                pop_valid_o <= pop_acc && !flush_i;
                if (pop_acc && !flush_i) begin
                    pop_data_o <= rd_data;
                end
            end
        end
    end else begin : g_rd_fwft
        // Head word is masked while empty so stale memory never leaks out.
        assign pop_valid_o = !fifo_empty_o;
        assign pop_data_o  = fifo_empty_o ? '0 : rd_data;
    end

`ifndef SYNTHESIS
    a_cnt_max:    assert property (@(posedge clk) disable iff (!reset) int'(count_o) <= DEPTH);
    a_full_cnt:   assert property (@(posedge clk) disable iff (!reset) fifo_full_o |-> int'(count_o) == DEPTH);
    a_empty_cnt:  assert property (@(posedge clk) disable iff (!reset) fifo_empty_o |-> count_o == '0);
    a_full_empty: assert property (@(posedge clk) disable iff (!reset) !(fifo_full_o && fifo_empty_o));
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, flush, push, pop, err_clr;
    logic [7:0] wdata;

    logic [7:0] a_pd, b_pd, c_pd;
    logic       a_pv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic       b_pv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic       c_pv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [4:0] a_cnt, c_cnt;
    logic [2:0] b_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] q16[$];
    logic [7:0] q5[$];
    logic [7:0] qf[$];

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) u16 (
        .clk(clk), .reset(rst_n), .flush_i(flush), .push_i(push), .push_data_i(wdata),
        .pop_i(pop), .pop_data_o(a_pd), .pop_valid_o(a_pv), .fifo_full_o(a_full),
        .fifo_empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .count_o(a_cnt), .overflow_o(a_ovf), .underflow_o(a_udf), .err_clr_i(err_clr));

    sync_fifo_ctrl #(.DATA_W(8), .DEPTH(5), .FWFT(1'b0)) u5 (
        .clk(clk), .reset(rst_n), .flush_i(flush), .push_i(push), .push_data_i(wdata),
        .pop_i(pop), .pop_data_o(b_pd), .pop_valid_o(b_pv), .fifo_full_o(b_full),
        .fifo_empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .count_o(b_cnt), .overflow_o(b_ovf), .underflow_o(b_udf), .err_clr_i(err_clr));

    sync_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) ufw (
        .clk(clk), .reset(rst_n), .flush_i(flush), .push_i(push), .push_data_i(wdata),
        .pop_i(pop), .pop_data_o(c_pd), .pop_valid_o(c_pv), .fifo_full_o(c_full),
        .fifo_empty_o(c_empty), .almost_full_o(c_af), .almost_empty_o(c_ae),
        .count_o(c_cnt), .overflow_o(c_ovf), .underflow_o(c_udf), .err_clr_i(err_clr));

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clean();
        push = 0; pop = 0; flush = 1; err_clr = 1;
        step();
        flush = 0; err_clr = 0;
        q16.delete(); q5.delete(); qf.delete();
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; push = 0; pop = 0; err_clr = 0; wdata = 8'h00;
        step(); step();
        checks++;
        if ({a_full, a_empty, a_af, a_ae, a_pv, a_ovf, a_udf} !== 7'b0101000 || a_cnt !== 5'd0 || a_pd !== 8'h00) begin
            errors++; $display("FAIL reset_u16: flags=%b cnt=%0d pd=%h want flags=0101000 cnt=0 pd=00",
                {a_full, a_empty, a_af, a_ae, a_pv, a_ovf, a_udf}, a_cnt, a_pd);
        end
        checks++;
        if ({b_full, b_empty, b_af, b_ae, b_pv, b_ovf, b_udf} !== 7'b0101000 || b_cnt !== 3'd0 || b_pd !== 8'h00) begin
            errors++; $display("FAIL reset_u5: flags=%b cnt=%0d pd=%h want flags=0101000 cnt=0 pd=00",
                {b_full, b_empty, b_af, b_ae, b_pv, b_ovf, b_udf}, b_cnt, b_pd);
        end
        checks++;
        if ({c_full, c_empty, c_af, c_ae, c_pv, c_ovf, c_udf} !== 7'b0101000 || c_cnt !== 5'd0 || c_pd !== 8'h00) begin
            errors++; $display("FAIL reset_fwft: flags=%b cnt=%0d pd=%h want flags=0101000 cnt=0 pd=00",
                {c_full, c_empty, c_af, c_ae, c_pv, c_ovf, c_udf}, c_cnt, c_pd);
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            push = 1; wdata = 8'(i); q16.push_back(8'(i));
            step();
            checks++;
            if (a_cnt !== 5'(i + 1) || a_af !== (i + 1 >= 14) || a_ae !== (i + 1 <= 2)) begin
                errors++; $display("FAIL fill_level: cnt=%0d af=%b ae=%b want cnt=%0d af=%b ae=%b",
                    a_cnt, a_af, a_ae, i + 1, (i + 1 >= 14), (i + 1 <= 2));
            end
        end
        push = 0;
        checks++;
        if (a_full !== 1'b1 || a_empty !== 1'b0 || a_cnt !== 5'd16) begin
            errors++; $display("FAIL fill_full: full=%b empty=%b cnt=%0d want 1 0 16", a_full, a_empty, a_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            pop = 1; exp = q16.pop_front();
            step();
            checks++;
            if (a_pv !== 1'b1 || a_pd !== exp) begin
                errors++; $display("FAIL drain_data: pv=%b pd=%h want pv=1 pd=%h", a_pv, a_pd, exp);
            end
        end
        pop = 0;
        step();
        checks++;
        if (a_pv !== 1'b0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_pd !== 8'h0F) begin
            errors++; $display("FAIL drain_end: pv=%b empty=%b full=%b pd=%h want 0 1 0 0f", a_pv, a_empty, a_full, a_pd);
        end
    endtask

    task automatic test_wrap_depth5();
        logic [7:0] exp;
        int k = 0;
        int n;
        clean();
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 2 : 5;
            for (int j = 0; j < n; j++) begin
                push = 1; wdata = 8'hA0 + 8'(k); q5.push_back(8'hA0 + 8'(k)); k++;
                step();
                checks++;
                if (b_cnt !== 3'(j + 1)) begin
                    errors++; $display("FAIL wrap_count: cnt=%0d want %0d", b_cnt, j + 1);
                end
            end
            push = 0;
            checks++;
            if (b_full !== (n == 5)) begin
                errors++; $display("FAIL wrap_full: full=%b want %b", b_full, (n == 5));
            end
            for (int j = 0; j < n; j++) begin
                pop = 1; exp = q5.pop_front();
                step();
                checks++;
                if (b_pv !== 1'b1 || b_pd !== exp) begin
                    errors++; $display("FAIL wrap_data: pv=%b pd=%h want pv=1 pd=%h", b_pv, b_pd, exp);
                end
            end
            pop = 0;
            step();
            checks++;
            if (b_empty !== 1'b1 || b_cnt !== 3'd0 || b_ovf !== 1'b0 || b_udf !== 1'b0) begin
                errors++; $display("FAIL wrap_empty: empty=%b cnt=%0d ovf=%b udf=%b want 1 0 0 0", b_empty, b_cnt, b_ovf, b_udf);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        clean();
        for (int i = 0; i < 16; i++) begin
            push = 1; wdata = 8'h40 + 8'(i); q16.push_back(8'h40 + 8'(i));
            step();
        end
        pop = 1; wdata = 8'h77; exp = q16.pop_front(); q16.push_back(8'h77);
        step();
        checks++;
        if (a_cnt !== 5'd16 || a_full !== 1'b1 || a_ovf !== 1'b0 || a_pv !== 1'b1 || a_pd !== exp) begin
            errors++; $display("FAIL full_pushpop: cnt=%0d full=%b ovf=%b pv=%b pd=%h want 16 1 0 1 %h",
                a_cnt, a_full, a_ovf, a_pv, a_pd, exp);
        end
        pop = 0; wdata = 8'h88;
        step();
        push = 0;
        checks++;
        if (a_ovf !== 1'b1 || a_cnt !== 5'd16) begin
            errors++; $display("FAIL overflow_set: ovf=%b cnt=%0d want 1 16", a_ovf, a_cnt);
        end
        step();
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_hold: ovf=%b want 1", a_ovf);
        end
        push = 1; err_clr = 1;
        step();
        push = 0;
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_set_wins: ovf=%b want 1", a_ovf);
        end
        step();
        err_clr = 0;
        checks++;
        if (a_ovf !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: ovf=%b want 0", a_ovf);
        end
        for (int i = 0; i < 16; i++) begin
            pop = 1; exp = q16.pop_front();
            step();
            checks++;
            if (a_pd !== exp) begin
                errors++; $display("FAIL full_drain: pd=%h want %h", a_pd, exp);
            end
        end
        pop = 0;
        step();
    endtask

    task automatic test_fwft();
        clean();
        push = 1; wdata = 8'h5A; qf.push_back(8'h5A);
        step();
        push = 0;
        checks++;
        if (c_pv !== 1'b1 || c_pd !== qf[0] || c_empty !== 1'b0) begin
            errors++; $display("FAIL fwft_show: pv=%b pd=%h empty=%b want 1 %h 0", c_pv, c_pd, c_empty, qf[0]);
        end
        pop = 1; void'(qf.pop_front());
        step();
        pop = 0;
        checks++;
        if (c_empty !== 1'b1 || c_pv !== 1'b0 || c_udf !== 1'b0) begin
            errors++; $display("FAIL fwft_pop: empty=%b pv=%b udf=%b want 1 0 0", c_empty, c_pv, c_udf);
        end
        pop = 1;
        step();
        pop = 0;
        checks++;
        if (c_udf !== 1'b1) begin
            errors++; $display("FAIL fwft_underflow: udf=%b want 1", c_udf);
        end
        for (int i = 0; i < 3; i++) begin
            push = 1; wdata = 8'hC0 + 8'(i); qf.push_back(8'hC0 + 8'(i));
            step();
        end
        push = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c_pv !== 1'b1 || c_pd !== qf[0]) begin
                errors++; $display("FAIL fwft_stream: pv=%b pd=%h want 1 %h", c_pv, c_pd, qf[0]);
            end
            pop = 1; void'(qf.pop_front());
            step();
        end
        pop = 0;
        checks++;
        if (c_empty !== 1'b1 || c_cnt !== 5'd0) begin
            errors++; $display("FAIL fwft_empty: empty=%b cnt=%0d want 1 0", c_empty, c_cnt);
        end
    endtask

    task automatic test_flush();
        clean();
        pop = 1;
        step();
        pop = 0;
        for (int i = 0; i < 7; i++) begin
            push = 1; wdata = 8'h10 + 8'(i);
            step();
        end
        checks++;
        if (a_cnt !== 5'd7 || a_udf !== 1'b1) begin
            errors++; $display("FAIL flush_pre: cnt=%0d udf=%b want 7 1", a_cnt, a_udf);
        end
        flush = 1; push = 1; wdata = 8'hEE;
        step();
        flush = 0; push = 0;
        checks++;
        if (a_cnt !== 5'd0 || a_empty !== 1'b1 || a_ae !== 1'b1 || a_pv !== 1'b0 || a_udf !== 1'b1 || a_ovf !== 1'b0) begin
            errors++; $display("FAIL flush_state: cnt=%0d empty=%b ae=%b pv=%b udf=%b ovf=%b want 0 1 1 0 1 0",
                a_cnt, a_empty, a_ae, a_pv, a_udf, a_ovf);
        end
        push = 1; wdata = 8'h21;
        step();
        push = 0;
        checks++;
        if (a_cnt !== 5'd1) begin
            errors++; $display("FAIL flush_drop: cnt=%0d want 1", a_cnt);
        end
        pop = 1;
        step();
        pop = 0;
        checks++;
        if (a_pv !== 1'b1 || a_pd !== 8'h21) begin
            errors++; $display("FAIL flush_after: pv=%b pd=%h want 1 21", a_pv, a_pd);
        end
    endtask

    task automatic test_async_reset();
        clean();
        for (int i = 0; i < 9; i++) begin
            push = 1; wdata = 8'h60 + 8'(i);
            step();
        end
        checks++;
        if (a_cnt !== 5'd9) begin
            errors++; $display("FAIL areset_pre: cnt=%0d want 9", a_cnt);
        end
        rst_n = 0;
        #2;
        checks++;
        if ({a_full, a_empty, a_af, a_ae, a_pv, a_ovf, a_udf} !== 7'b0101000 || a_cnt !== 5'd0 || a_pd !== 8'h00) begin
            errors++; $display("FAIL areset_now: flags=%b cnt=%0d pd=%h want flags=0101000 cnt=0 pd=00",
                {a_full, a_empty, a_af, a_ae, a_pv, a_ovf, a_udf}, a_cnt, a_pd);
        end
        push = 0;
        step(); step();
        rst_n = 1;
        push = 1; wdata = 8'h33;
        step();
        push = 0; pop = 1;
        step();
        pop = 0;
        checks++;
        if (a_pv !== 1'b1 || a_pd !== 8'h33 || a_empty !== 1'b1) begin
            errors++; $display("FAIL areset_after: pv=%b pd=%h empty=%b want 1 33 1", a_pv, a_pd, a_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap_depth5();
        test_full_push_pop();
        test_fwft();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
